gmsk_frame_sync: RTL and testbench

//  Stage downstream of demod_gmsk. Slices the per-symbol signed frequency estimate into hard bits.

---
 rtl/gmsk_frame_sync_if.sv | 28 ++
 rtl/gmsk_frame_sync.sv | 180 ++++++++++++++++++
 tb/tb_gmsk_frame_sync.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gmsk_frame_sync_if.sv
// rtl/gmsk_frame_sync_if.sv - symbol-in / bit, sync and payload-byte-out bundle for gmsk_frame_sync
interface gmsk_frame_sync_if #(
    parameter int FW = 6
);
    logic                 en;
    logic                 sym_valid;
    logic signed [FW-1:0] freq;
    logic                 bit_valid;
    logic                 bit_out;
    logic                 sync_found;
    logic                 byte_valid;
    logic [7:0]           byte_out;
    logic                 frame_done;
    logic                 crc_ok;
    logic                 in_frame;

    modport master (
        output en, sym_valid, freq,
        input  bit_valid, bit_out, sync_found, byte_valid, byte_out,
        input  frame_done, crc_ok, in_frame
    );

    modport slave (
        input  en, sym_valid, freq,
        output bit_valid, bit_out, sync_found, byte_valid, byte_out,
        output frame_done, crc_ok, in_frame
    );
endinterface

// File: rtl/gmsk_frame_sync.sv
// rtl/gmsk_frame_sync.sv - GMSK bit slicer, sync-word correlator and payload byte packer (optional CRC-8 via FRAME_CRC_EN)
module gmsk_frame_sync #(
    parameter int                FW            = 6,
    parameter int                THRESH        = 2,
    parameter int                SYNC_LEN      = 16,
    parameter logic [31:0]       SYNC_WORD     = 32'h0000_D391,
    parameter int                MAX_ERR       = 1,
    parameter int                PAYLOAD_BYTES = 8
) (
    input  logic               clk,
    input  logic               rst,
    gmsk_frame_sync_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PAYLOAD} state_t;

    localparam int                   FILL_W = $clog2(SYNC_LEN + 1);
    localparam logic [FILL_W-1:0]    L_FULL = FILL_W'(SYNC_LEN);
    localparam logic [SYNC_LEN-1:0]  L_SYNC = SYNC_WORD[SYNC_LEN-1:0];
    localparam logic signed [FW-1:0] L_POS  = FW'(THRESH);
    localparam logic signed [FW-1:0] L_NEG  = FW'(-THRESH);
    localparam logic [7:0]           L_LAST = 8'(PAYLOAD_BYTES - 1);

    state_t                r_state;
    logic                  r_prev_bit;
    logic [SYNC_LEN-1:0]   r_shreg;
    logic [FILL_W-1:0]     r_fill;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_byte_cnt;
    logic [6:0]            r_byte_sr;
    logic                  r_bit_valid;
    logic                  r_bit_out;
    logic                  r_sync_found;
    logic                  r_byte_valid;
    logic [7:0]            r_byte_out;
    logic                  r_frame_done;
    logic                  r_crc_ok;
    logic                  r_in_frame;

    logic                  w_sym;
    logic                  w_bit;
    logic [SYNC_LEN-1:0]   w_shreg_nxt;
    logic [FILL_W-1:0]     w_fill_nxt;
    logic                  w_match;
    logic [7:0]            w_byte_nxt;
    logic                  w_last_byte;
    logic                  w_crc_ok;

    function automatic int popcnt(input logic [SYNC_LEN-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SYNC_LEN; i++) n += int'(v[i]);
        return n;
    endfunction

    // Dead-band inside +/-THRESH repeats the last decision instead of guessing.
    assign w_sym       = bus.en & bus.sym_valid;
    assign w_bit       = (bus.freq > L_POS) ? 1'b1 :
                         (bus.freq < L_NEG) ? 1'b0 : r_prev_bit;
    // Correlation runs on the window that already contains the current bit.
    assign w_shreg_nxt = {r_shreg[SYNC_LEN-2:0], w_bit};
    assign w_fill_nxt  = (r_fill == L_FULL) ? r_fill : r_fill + 1'b1;
    assign w_match     = (w_fill_nxt == L_FULL) && (popcnt(w_shreg_nxt ^ L_SYNC) <= MAX_ERR);
    assign w_byte_nxt  = {r_byte_sr, w_bit};
    assign w_last_byte = (r_bit_cnt == 3'd7) && (r_byte_cnt == L_LAST);

`ifdef FRAME_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_nxt;

    // CRC-8 poly 0x07, MSB-first; the transmitted CRC byte drives the remainder to zero.
    assign w_crc_nxt = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ w_bit) ? 8'h07 : 8'h00);
    assign w_crc_ok  = (w_crc_nxt == 8'h00);

    // CRC register: cleared on sync, updated on every payload bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 8'h00;
        end else if (!bus.en) begin
            r_crc <= 8'h00;
        end else if (r_state == S_SEARCH && w_sym && w_match) begin
            r_crc <= 8'h00;
        end else if (r_state == S_PAYLOAD && w_sym) begin
            r_crc <= w_crc_nxt;
        end
    end
`else
    assign w_crc_ok = 1'b1;
`endif

    // Slicer, correlator and payload packer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev_bit   <= 1'b0;
            r_shreg      <= '0;
            r_fill       <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_byte_sr    <= '0;
            r_bit_valid  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_sync_found <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_out   <= '0;
            r_frame_done <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_in_frame   <= 1'b0;
        end else begin
            r_bit_valid  <= 1'b0;
            r_sync_found <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_ok     <= 1'b0;
            if (!bus.en) begin
                // Abort: drop any partial frame silently, but keep prev_bit for the slicer.
                r_state    <= S_IDLE;
                r_shreg    <= '0;
                r_fill     <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_byte_sr  <= '0;
                r_in_frame <= 1'b0;
            end else begin
                if (w_sym) begin
                    r_prev_bit  <= w_bit;
                    r_bit_valid <= 1'b1;
                    r_bit_out   <= w_bit;
                end
                case (r_state)
                    S_IDLE, S_SEARCH: begin
                        r_in_frame <= 1'b0;
                        if (r_state == S_IDLE) r_state <= S_SEARCH;
                        if (w_sym) begin
                            r_shreg <= w_shreg_nxt;
                            r_fill  <= w_fill_nxt;
                            if (r_state == S_SEARCH && w_match) begin
                                r_state      <= S_PAYLOAD;
                                r_sync_found <= 1'b1;
                                r_in_frame   <= 1'b1;
                                r_bit_cnt    <= '0;
                                r_byte_cnt   <= '0;
                                r_byte_sr    <= '0;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_sym) begin
                            r_byte_sr <= w_byte_nxt[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte_valid <= 1'b1;
                                r_byte_out   <= w_byte_nxt;
                                r_byte_cnt   <= r_byte_cnt + 8'd1;
                            end
                            if (w_last_byte) begin
                                // Clearing the window keeps payload bits from faking a sync.
                                r_frame_done <= 1'b1;
                                r_crc_ok     <= w_crc_ok;
                                r_state      <= S_SEARCH;
                                r_shreg      <= '0;
                                r_fill       <= '0;
                                r_byte_cnt   <= '0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.bit_valid  = r_bit_valid;
    assign bus.bit_out    = r_bit_out;
    assign bus.sync_found = r_sync_found;
    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_out   = r_byte_out;
    assign bus.frame_done = r_frame_done;
    assign bus.crc_ok     = r_crc_ok;
    assign bus.in_frame   = r_in_frame;
endmodule

// File: tb/tb_gmsk_frame_sync.sv
// tb/tb_gmsk_frame_sync.sv - scoreboard bench for gmsk_frame_sync
module tb_gmsk_frame_sync;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gmsk_frame_sync_if #(.FW(6)) bus();
    gmsk_frame_sync dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_sync  = 0;
    int         n_frames = 0;
    logic       q_bits[$];
    logic [7:0] q_bytes[$];
    logic [7:0] pl[8];
    logic       m_prev;
    logic       e_bit;
    logic [7:0] e_byte;
    logic       exp_ok;
    int         s0;
    int         f0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_upd(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    // Scoreboard: every DUT strobe pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sync_found) begin
                n_sync++;
                chk("sync_with_bit_valid", bus.bit_valid, 1);
            end
            if (bus.frame_done) begin
                n_frames++;
                chk("frame_done_with_byte", bus.byte_valid, 1);
            end
            if (bus.bit_valid) begin
                if (q_bits.size() == 0) chk("bit_unexpected", 1, 0);
                else begin
                    e_bit = q_bits.pop_front();
                    chk("bit_out", bus.bit_out, e_bit);
                end
            end
            if (bus.byte_valid) begin
                if (q_bytes.size() == 0) chk("byte_unexpected", 1, 0);
                else begin
                    e_byte = q_bytes.pop_front();
                    chk("byte_out", bus.byte_out, e_byte);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input int f);
        logic b;
        bus.freq      = 6'(f);
        bus.sym_valid = 1'b1;
        if (bus.en) begin
            b = (f > 2) ? 1'b1 : (f < -2) ? 1'b0 : m_prev;
            m_prev = b;
            q_bits.push_back(b);
        end
        tick();
        bus.sym_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sym(v[i] ? 20 : -20);
    endtask

    task automatic send_byte(input logic [7:0] v);
        q_bytes.push_back(v);
        send_bits({24'h0, v}, 8);
    endtask

    task automatic send_payload(input logic [7:0] flip, output logic ok);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = (i == 0) ? (pl[i] ^ flip) : pl[i];
            c = crc8_upd(c, b);
            send_byte(b);
        end
`ifdef FRAME_CRC_EN
        ok = (c == 8'h00);
`else
        ok = 1'b1;
`endif
    endtask

    task automatic restart();
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
    endtask

    initial begin
        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'h5A; pl[3] = 8'hC3;
        pl[4] = 8'h0F; pl[5] = 8'hF0; pl[6] = 8'h99;
        pl[7] = 8'h00;
        for (int i = 0; i < 7; i++) pl[7] = crc8_upd(pl[7], pl[i]);

        bus.en = 1'b0; bus.sym_valid = 1'b0; bus.freq = '0;
        m_prev = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_bit_valid", bus.bit_valid, 0);
        chk("rst_bit_out", bus.bit_out, 0);
        chk("rst_sync_found", bus.sync_found, 0);
        chk("rst_byte_valid", bus.byte_valid, 0);
        chk("rst_byte_out", bus.byte_out, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_crc_ok", bus.crc_ok, 0);
        chk("rst_in_frame", bus.in_frame, 0);

        // Slicer with dead-band and one-cycle latency
        bus.en = 1'b1;
        tick();
        sym(5);  chk("lat_bit_valid", bus.bit_valid, 1); chk("slice_p5", bus.bit_out, 1);
        tick();  chk("strobe_one_cycle", bus.bit_valid, 0);
        sym(-5); chk("slice_m5", bus.bit_out, 0);
        sym(1);  chk("slice_p1_hold", bus.bit_out, 0);
        sym(-1); chk("slice_m1_hold", bus.bit_out, 0);
        sym(-3); chk("slice_m3", bus.bit_out, 0);
        sym(3);  chk("slice_p3", bus.bit_out, 1);
        sym(0);  chk("slice_0_hold1", bus.bit_out, 1);

        // sym_valid ignored while disabled
        bus.en = 1'b0;
        tick();
        sym(-20);
        chk("en0_no_bit_valid", bus.bit_valid, 0);
        chk("en0_bit_out_held", bus.bit_out, 1);
        bus.en = 1'b1;
        tick();

        // Exact sync word and full frame
        s0 = n_sync; f0 = n_frames;
        send_bits(32'hD391, 16);
        chk("sync_exact", bus.sync_found, 1);
        chk("in_frame_after_sync", bus.in_frame, 1);
        send_payload(8'h00, exp_ok);
        chk("frame_done_1", bus.frame_done, 1);
        chk("crc_ok_1", bus.crc_ok, exp_ok);
        chk("in_frame_at_done", bus.in_frame, 1);
        tick();
        chk("in_frame_fall", bus.in_frame, 0);
        chk("frame_done_pulse", bus.frame_done, 0);
        chk("byte_out_hold", bus.byte_out, pl[7]);
        chk("sync_count_1", n_sync - s0, 1);
        chk("frame_count_1", n_frames - f0, 1);

        // One bit error accepted, two rejected
        restart();
        send_bits(32'hD393, 16);
        chk("sync_1err", bus.sync_found, 1);
        send_payload(8'h00, exp_ok);
        chk("frame_done_2", bus.frame_done, 1);
        restart();
        s0 = n_sync;
        send_bits(32'hD397, 16);
        tick();
        chk("no_sync_2err", n_sync - s0, 0);
        chk("stay_search", bus.in_frame, 0);

        // Enable drop mid-payload, then recovery
        restart();
        f0 = n_frames;
        send_bits(32'hD391, 16);
        for (int i = 0; i < 3; i++) send_byte(pl[i]);
        bus.en = 1'b0;
        tick();
        chk("en_drop_in_frame", bus.in_frame, 0);
        chk("en_drop_frame_done", bus.frame_done, 0);
        repeat (3) tick();
        chk("en_drop_no_frame", n_frames - f0, 0);
        bus.en = 1'b1;
        tick();
        send_bits(32'hD391, 16);
        chk("resync_after_en", bus.sync_found, 1);
        send_payload(8'h00, exp_ok);
        chk("frame_done_3", bus.frame_done, 1);

        // Asynchronous reset mid-payload, then fill guard
        restart();
        send_bits(32'hD391, 16);
        send_byte(pl[0]);
        send_byte(pl[1]);
        send_bits(32'h5, 3);
        chk("pre_rst_in_frame", bus.in_frame, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_frame", bus.in_frame, 0);
        chk("arst_byte_out", bus.byte_out, 0);
        chk("arst_bit_out", bus.bit_out, 0);
        chk("arst_bit_valid", bus.bit_valid, 0);
        m_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        s0 = n_sync;
        send_bits(32'hD391 >> 1, 15);
        tick();
        chk("fill_guard_15", n_sync - s0, 0);
        send_bits(32'h1, 1);
        chk("sync_16th_bit", bus.sync_found, 1);
        send_payload(8'h00, exp_ok);
        chk("frame_done_4", bus.frame_done, 1);
        chk("crc_ok_good", bus.crc_ok, exp_ok);

        // Corrupted payload bit
        restart();
        send_bits(32'hD391, 16);
        send_payload(8'h10, exp_ok);
        chk("frame_done_5", bus.frame_done, 1);
        chk("crc_ok_flip", bus.crc_ok, exp_ok);
        tick();
        chk("crc_ok_pulse", bus.crc_ok, 0);

        repeat (3) tick();
        chk("bits_drained", q_bits.size(), 0);
        chk("bytes_drained", q_bytes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
